// File: rtl/slime_pkg.sv
// rtl/slime_pkg.sv - shared encodings, coordinate width and BCD digit increment for the slime engine
package slime_pkg;
  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam logic [1:0] ST_JUMP = 2'd0;
  localparam logic [1:0] ST_FALL = 2'd1;
  localparam logic [1:0] ST_DEAD = 2'd2;

  localparam logic [1:0] DIR_INIT  = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_RIGHT = 2'd2;

  // Returns {carry_out, digit}; a digit of 9 with carry in rolls to 0.
  function automatic logic [4:0] bcd_digit_inc(input logic [3:0] d, input logic cin);
    if (!cin) return {1'b0, d};
    if (d == 4'd9) return 5'b1_0000;
    return {1'b0, d + 4'd1};
  endfunction
endpackage

// File: rtl/slime_physics_if.sv
// rtl/slime_physics_if.sv - key/platform inputs and position/score outputs of the slime engine
interface slime_physics_if #(
  parameter int N_FLOOR      = 8,
  parameter int SCORE_DIGITS = 2
);
  import slime_pkg::*;
  localparam int IDX_W = (N_FLOOR > 1) ? $clog2(N_FLOOR) : 1;

  logic                         clk_vga;
  logic [1:0]                   key;
  logic [COORD_W*N_FLOOR-1:0]   floor_x;
  logic [COORD_W*N_FLOOR-1:0]   floor_y;
  logic [N_FLOOR-1:0]           enable;
  coord_t                       x;
  coord_t                       y;
  logic                         hit_ceiling;
  logic                         slime_die;
  logic [4*SCORE_DIGITS-1:0]    score;
  logic                         land_pulse;
  logic [IDX_W-1:0]             land_idx;

  modport master (
    output clk_vga, key, floor_x, floor_y, enable,
    input  x, y, hit_ceiling, slime_die, score, land_pulse, land_idx
  );
  modport slave (
    input  clk_vga, key, floor_x, floor_y, enable,
    output x, y, hit_ceiling, slime_die, score, land_pulse, land_idx
  );
endinterface

// File: rtl/slime_floor_hit.sv
// rtl/slime_floor_hit.sv - per-platform landing check with lowest-index priority select
module slime_floor_hit
  import slime_pkg::*;
#(
  parameter int N_FLOOR = 8,
  parameter int SLIME_W = 20,
  parameter int FLOOR_W = 40,
  parameter int IDX_W   = 3
) (
  input  coord_t                     x,
  input  coord_t                     y,
  input  logic [COORD_W*N_FLOOR-1:0] floor_x,
  input  logic [COORD_W*N_FLOOR-1:0] floor_y,
  input  logic [N_FLOOR-1:0]         enable,
  output logic                       hit,
  output logic [IDX_W-1:0]           idx
);
  logic [N_FLOOR-1:0] match;
  coord_t             x_right;

  assign x_right = x + coord_t'(SLIME_W);

  for (genvar i = 0; i < N_FLOOR; i++) begin : g_match
    coord_t fx, fy, fx_end;
    assign fx     = floor_x[COORD_W*i +: COORD_W];
    assign fy     = floor_y[COORD_W*i +: COORD_W];
    assign fx_end = fx + coord_t'(FLOOR_W);
    // fy==0 would alias to row 1023 under modulo arithmetic, so it is excluded
    assign match[i] = enable[i] && (fy != '0) && (y == fy - coord_t'(1)) &&
                      (((x >= fx) && (x <= fx_end)) ||
                       ((x_right >= fx) && (x_right <= fx_end)));
  end

  always_comb begin
    hit = |match;
    idx = '0;
    for (int i = N_FLOOR - 1; i >= 0; i--) begin
      if (match[i]) idx = IDX_W'(i);
    end
  end
endmodule

// File: rtl/slime_physics.sv
// rtl/slime_physics.sv - slime motion, jump/fall FSM, BCD score; SLIME_WRAP_EN wraps x at screen edges
module slime_physics
  import slime_pkg::*;
#(
  parameter int N_FLOOR      = 8,
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int SLIME_W      = 20,
  parameter int FLOOR_W      = 40,
  parameter int PHASE_LEN    = 80,
  parameter int CEIL_Y       = 240,
  parameter int SCORE_DIGITS = 2,
  parameter int START_X      = 310,
  parameter int START_Y      = 379
) (
  input  logic           clk,
  input  logic           rst,
  slime_physics_if.slave bus
);
  localparam int     IDX_W = (N_FLOOR > 1) ? $clog2(N_FLOOR) : 1;
  localparam coord_t X_MAX = coord_t'(SCREEN_W - SLIME_W - 1);
  localparam coord_t Y_DIE = coord_t'(SCREEN_H - 1);
  localparam coord_t Y_CEIL = coord_t'(CEIL_Y);
  localparam int     P     = PHASE_LEN;

  logic [1:0]                dir, state;
  logic [8:0]                t;
  coord_t                    x_q, y_q, x_next;
  logic                      hc, die, lp;
  logic [IDX_W-1:0]          li, hit_idx;
  logic [4*SCORE_DIGITS-1:0] score_q, score_inc;
  logic                      score_ovf, hit, jump_step, fall_step;
  logic [4:0]                dig;

  slime_floor_hit #(
    .N_FLOOR(N_FLOOR), .SLIME_W(SLIME_W), .FLOOR_W(FLOOR_W), .IDX_W(IDX_W)
  ) u_floor_hit (
    .x(x_q), .y(y_q), .floor_x(bus.floor_x), .floor_y(bus.floor_y),
    .enable(bus.enable), .hit(hit), .idx(hit_idx)
  );

  // Rise slows and fall speeds up by halving/doubling the step rate each phase
  always_comb begin
    jump_step = 1'b0;
    fall_step = 1'b1;
    if (t < 9'(P)) begin
      jump_step = (t != 9'd0);
      fall_step = (t[2:0] == 3'd0);
    end else if (t < 9'(2*P)) begin
      jump_step = ~t[0];
      fall_step = (t[1:0] == 2'd0);
    end else if (t < 9'(3*P)) begin
      jump_step = (t[1:0] == 2'd0);
      fall_step = ~t[0];
    end else if (t < 9'(4*P)) begin
      jump_step = (t[2:0] == 3'd0);
    end
  end

  always_comb begin
    x_next = x_q;
    if (dir == DIR_LEFT) begin
      if (x_q == '0) begin
`ifdef SLIME_WRAP_EN
        x_next = X_MAX;
`else
        x_next = '0;
`endif
      end else begin
        x_next = x_q - coord_t'(1);
      end
    end else if (dir == DIR_RIGHT) begin
      if (x_q >= X_MAX) begin
`ifdef SLIME_WRAP_EN
        x_next = '0;
`else
        x_next = X_MAX;
`endif
      end else begin
        x_next = x_q + coord_t'(1);
      end
    end
  end

  always_comb begin
    score_inc = score_q;
    score_ovf = 1'b1;
    dig       = '0;
    for (int d = 0; d < SCORE_DIGITS; d++) begin
      dig = bcd_digit_inc(score_q[4*d +: 4], score_ovf);
      score_inc[4*d +: 4] = dig[3:0];
      score_ovf = dig[4];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dir     <= DIR_INIT;
      state   <= ST_FALL;
      t       <= 9'd1;
      x_q     <= coord_t'(START_X);
      y_q     <= coord_t'(START_Y);
      hc      <= 1'b0;
      die     <= 1'b0;
      lp      <= 1'b0;
      li      <= '0;
      score_q <= '0;
    end else begin
      lp <= 1'b0;
      if (bus.key == 2'b10)      dir <= DIR_LEFT;
      else if (bus.key == 2'b01) dir <= DIR_RIGHT;
      if (bus.clk_vga && state != ST_DEAD) begin
        x_q <= x_next;
        if (state == ST_JUMP) begin
          if (t == 9'(4*P)) begin
            state <= ST_FALL;
            t     <= 9'd1;
            hc    <= 1'b0;
          end else begin
            t <= t + 9'd1;
            // a scrolling jump keeps y still while the world moves down
            if (jump_step && !hc) y_q <= y_q - coord_t'(1);
          end
        end else if (y_q == Y_DIE) begin
          state <= ST_DEAD;
          die   <= 1'b1;
        end else if (hit) begin
          state <= ST_JUMP;
          t     <= 9'd1;
          li    <= hit_idx;
          lp    <= 1'b1;
          hc    <= (y_q < Y_CEIL);
          if (y_q < Y_CEIL) begin
            if (score_ovf) begin
              state <= ST_DEAD;
              die   <= 1'b1;
            end else begin
              score_q <= score_inc;
            end
          end
        end else begin
          if (fall_step) y_q <= y_q + coord_t'(1);
          if (t != 9'(4*P)) t <= t + 9'd1;
        end
      end
    end
  end

  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.hit_ceiling = hc;
  assign bus.slime_die   = die;
  assign bus.score       = score_q;
  assign bus.land_pulse  = lp;
  assign bus.land_idx    = li;
endmodule

// File: tb/tb_slime_physics.sv
// tb/tb_slime_physics.sv - directed self-checking bench for slime_physics
module tb_slime_physics;
  logic clk = 1'b0;
  logic rst;
  int   vec = 0;
  int   bad = 0;
  int   n;

  always #5 clk = ~clk;

  slime_physics_if #(.N_FLOOR(8), .SCORE_DIGITS(2)) bus ();

  slime_physics #(
    .N_FLOOR(8), .SCREEN_W(640), .SCREEN_H(480), .SLIME_W(20), .FLOOR_W(40),
    .PHASE_LEN(80), .CEIL_Y(240), .SCORE_DIGITS(2), .START_X(310), .START_Y(379)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bus.clk_vga = 1'b1;
    @(negedge clk);
    bus.clk_vga = 1'b0;
  endtask

  task automatic ticks(input int k);
    repeat (k) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.clk_vga = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.clk_vga = 1'b0;
  endtask

  task automatic set_floor(input int i, input int fx, input int fy);
    bus.floor_x[10*i +: 10] = fx[9:0];
    bus.floor_y[10*i +: 10] = fy[9:0];
    bus.enable[i] = 1'b1;
  endtask

  task automatic wait_land(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!bus.land_pulse && cnt < 400);
    chk("land_within_bound", bus.land_pulse, 1);
  endtask

  initial begin
    rst = 1'b1;
    bus.clk_vga = 1'b0;
    bus.key = 2'b00;
    bus.floor_x = '0;
    bus.floor_y = '0;
    bus.enable = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    chk("rst_x", bus.x, 310);
    chk("rst_y", bus.y, 379);
    chk("rst_die", bus.slime_die, 0);
    chk("rst_score", bus.score, 32'h00);
    chk("rst_pulse", bus.land_pulse, 0);
    chk("rst_idx", bus.land_idx, 0);
    chk("rst_hc", bus.hit_ceiling, 0);

    ticks(7);
    chk("fall_t7_y", bus.y, 379);
    tick();
    chk("fall_t8_y", bus.y, 380);
    ticks(2);
    chk("fall_t10_y", bus.y, 380);
    chk("fall_t10_x", bus.x, 310);

    set_floor(0, 300, 381);
    set_floor(1, 300, 349);
    set_floor(3, 300, 200);
    tick();
    chk("land0_pulse", bus.land_pulse, 1);
    chk("land0_idx", bus.land_idx, 0);
    chk("land0_hc", bus.hit_ceiling, 0);
    chk("land0_y", bus.y, 380);
    @(negedge clk);
    chk("land0_pulse_clr", bus.land_pulse, 0);
    chk("idle_y", bus.y, 380);
    ticks(319);
    chk("jump0_peak_y", bus.y, 231);
    tick();
    chk("jump0_end_y", bus.y, 231);
    wait_land(n);
    chk("fall1_ticks", n, 288);
    chk("land1_y", bus.y, 348);
    chk("land1_idx", bus.land_idx, 1);
    chk("land1_hc", bus.hit_ceiling, 0);
    ticks(319);
    chk("jump1_peak_y", bus.y, 199);
    tick();
    wait_land(n);
    chk("land3_ticks", n, 1);
    chk("land3_idx", bus.land_idx, 3);
    chk("land3_hc", bus.hit_ceiling, 1);
    chk("land3_score", bus.score, 32'h01);
    ticks(319);
    chk("scroll_hold_y", bus.y, 199);
    chk("scroll_hold_hc", bus.hit_ceiling, 1);
    tick();
    chk("scroll_end_hc", bus.hit_ceiling, 0);
    chk("scroll_end_y", bus.y, 199);
    tick();
    chk("land3b_pulse", bus.land_pulse, 1);
    chk("land3b_score", bus.score, 32'h02);
    for (int k = 0; k < 97; k++) wait_land(n);
    chk("score_99", bus.score, 32'h99);
    chk("score_99_alive", bus.slime_die, 0);
    wait_land(n);
    chk("ovf_ticks", n, 321);
    chk("ovf_score", bus.score, 32'h99);
    chk("ovf_die", bus.slime_die, 1);
    ticks(5);
    chk("dead_y", bus.y, 199);
    chk("dead_x", bus.x, 310);
    chk("dead_score", bus.score, 32'h99);

    do_reset();
    chk("rst2_die", bus.slime_die, 0);
    chk("rst2_score", bus.score, 32'h00);
    bus.enable = '0;
    set_floor(0, 300, 380);
    tick();
    chk("land_c_pulse", bus.land_pulse, 1);
    ticks(99);
    chk("jump_t100_y", bus.y, 290);
    do_reset();
    chk("midjump_rst_x", bus.x, 310);
    chk("midjump_rst_y", bus.y, 379);
    chk("midjump_rst_hc", bus.hit_ceiling, 0);
    chk("midjump_rst_pulse", bus.land_pulse, 0);
    bus.enable = '0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.slime_die && n < 400);
    chk("death_ticks", n, 271);
    chk("death_y", bus.y, 479);
    chk("death_die", bus.slime_die, 1);
    ticks(3);
    chk("death_frozen_y", bus.y, 479);

    do_reset();
    bus.enable = '0;
    set_floor(2, 331, 380);
    set_floor(6, 330, 380);
    tick();
    chk("edge_land_pulse", bus.land_pulse, 1);
    chk("edge_land_idx", bus.land_idx, 6);

    do_reset();
    bus.enable = '0;
    set_floor(1, 300, 380);
    set_floor(5, 295, 380);
    tick();
    chk("overlap_idx", bus.land_idx, 1);

    do_reset();
    bus.enable = '0;
    for (int i = 0; i < 8; i++) set_floor(i, 40 * i, 380);
    bus.key = 2'b10;
    @(negedge clk);
    chk("key_no_tick_x", bus.x, 310);
    bus.key = 2'b00;
    ticks(310);
    chk("left_x0", bus.x, 0);
    tick();
`ifdef SLIME_WRAP_EN
    chk("left_edge_x", bus.x, 619);
`else
    chk("left_edge_x", bus.x, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule

// File: doc/slime_physics.md
# slime_physics

Parametrised successor to the slime motion engine. Per VGA tick it computes the slime's position from the left/right key, the jump/fall velocity profile and collisions against N platforms. It also maintains a multi-digit BCD score and a latched death state. It sits between the key decoder, the platform generator (the floor arrays) and the renderer/scroller (x, y, hit_ceiling).

## Interface
- N_FLOOR, 8, number of platforms checked
- SCREEN_W, 640, playfield width in pixels
- SCREEN_H, 480, playfield height; bottom row SCREEN_H-1 kills
- SLIME_W, 20, slime width
- FLOOR_W, 40, platform width
- PHASE_LEN, 80, ticks per velocity phase
- CEIL_Y, 240, landing above this row scores and sets hit_ceiling
- SCORE_DIGITS, 2, BCD digits of score
- START_X, 310; START_Y, 379, reset position

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- clk_vga  in  1  one-cycle tick enable; all motion advances only on ticks
- key  in  2  2'b10 left, 2'b01 right, other values hold direction
- floor_x  in  10*N_FLOOR  packed platform left edges, entry i at [10i+:10]
- floor_y  in  10*N_FLOOR  packed platform top rows
- enable  in  N_FLOOR  platform i valid
- x, y  out  10 each  slime top-left
- hit_ceiling  out  1  current jump is a scrolling jump
- slime_die  out  1  latched death
- score  out  4*SCORE_DIGITS  BCD score, digit 0 in [3:0]
- land_pulse  out  1  one-cycle pulse on a landing tick
- land_idx  out  $clog2(N_FLOOR)  index of last platform landed on

## Operation
- Direction register (INIT/LEFT/RIGHT) updates every clk from key, not only on ticks.
- On a tick, x moves ±1 per the direction. INIT means no motion.
- Velocity FSM states: JUMP, FALL, DEAD. Counter t is 9 bits wide, P = PHASE_LEN.
- **JUMP:**
  - y decrements when:
    - t in [1,P): every tick
    - [P,2P): t[0]==0
    - [2P,3P): t[1:0]==0
    - [3P,4P): t[2:0]==0
  - t increments each tick.
  - When t==4P: go to FALL, t←1, hit_ceiling←0.
  - If hit_ceiling=1, y is held for the whole jump; the scroller moves the world instead.
- **FALL**, checks evaluated in priority order:
  - **Death:** y==SCREEN_H-1 → DEAD.
  - **Landing:** lowest i with enable[i], y==floor_y[i]-1, and x or x+SLIME_W inside [floor_x[i], floor_x[i]+FLOOR_W]:
    - JUMP, t←1, land_idx←i, land_pulse←1.
    - hit_ceiling←(y<CEIL_Y).
    - If y<CEIL_Y, score increments with BCD ripple carry.
  - **Otherwise:** y increments when:
    - t in [1,P): t[2:0]==0
    - [P,2P): t[1:0]==0
    - [2P,3P): t[0]==0
    - [3P,∞): every tick
  - t saturates at 4P.
- Score overflow: if incrementing would carry out of the top digit (all digits 9), score holds at all-9s and the state goes to DEAD.
- **DEAD:** x, y, score and t are frozen; slime_die=1. DEAD exits only via rst.

## Timing
- All outputs are registered. Updates take effect the cycle after the tick.
- Reset values:
  - x=START_X, y=START_Y
  - state FALL, t=1, direction INIT
  - hit_ceiling=0, slime_die=0, score=0, land_pulse=0, land_idx=0
- Key-to-direction latency is 1 clk. Direction-to-x latency is the next tick.
- land_pulse is high exactly one clk: the cycle after the landing tick.
- Non-tick cycles change only the direction register and clear land_pulse.
- rst asserted mid-jump restores all reset values on the next edge, regardless of clk_vga.
- All 10-bit arithmetic is unsigned modulo 1024. floor_y[i]=0 never matches a landing.

## Configuration
- SLIME_WRAP_EN defined:
  - LEFT at x=0 → x=SCREEN_W-SLIME_W-1 (619 at defaults).
  - RIGHT at x=SCREEN_W-SLIME_W-1 → x=0.
- SLIME_WRAP_EN undefined: x clamps at 0 and at SCREEN_W-SLIME_W-1; direction is kept.

## Structure
- Package slime_pkg holds:
  - state encoding (JUMP/FALL/DEAD) and direction encoding (INIT/LEFT/RIGHT)
  - 10-bit coordinate width constant
  - BCD increment function
- Sub-module slime_floor_hit:
  - combinational N_FLOOR overlap check plus lowest-index priority encoder
  - outputs hit and idx

## Test plan
- **Reset/start fall:** rst, then 10 ticks with no floors → x=310, y=380 (first step at t=8), state FALL, score=00.
- **Scoring landing:** enable[3]=1, floor_x3=300, floor_y3=200, slime falls to y=199 → land_pulse one cycle, land_idx=3, hit_ceiling=1, score=01, y held 4·80 ticks.
- **Overlapping platforms:** platforms 1 and 5 overlap at the same row → land_idx=1.
- **Edge motion:** key=2'b10 at x=0, one tick → x=619 with SLIME_WRAP_EN, x=0 without.
- **Score overflow:** score=99, landing at y=150 → score stays 99, slime_die=1, further ticks freeze x/y.
- **Reset mid-jump:** rst at t=100 of a jump → all reset values next cycle; falling to y=479 → slime_die latched.
